// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: per-channel bypass / light / full (skid) retiming of AW, W, B, AR, R.
// Optional outstanding-transaction limit enabled by defining AXI4_SLICE_OUTSTANDING_LIMIT_EN.

module axi4_reg_slice_stage #(
  parameter int WIDTH = 1,
  parameter int MODE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  generate
    if (MODE == 0) begin : g_bypass
      assign out_valid = in_valid & ~rst;
      assign in_ready  = out_ready & ~rst;
      assign out_data  = in_data;
    end else if (MODE == 1) begin : g_light
      logic             valid_reg, ready_reg, valid_next, load;
      logic [WIDTH-1:0] data_reg;

      assign load       = in_valid & ready_reg;
      assign valid_next = load | (valid_reg & ~out_ready);

      // ready_reg mirrors !valid_reg but stays low throughout reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b0;
        end else begin
          valid_reg <= valid_next;
          ready_reg <= ~valid_next;
        end
      end

      always_ff @(posedge clk) begin
        if (load) data_reg <= in_data;
      end

      assign in_ready  = ready_reg;
      assign out_valid = valid_reg;
      assign out_data  = data_reg;
    end else begin : g_full
      logic             main_valid_reg, skid_valid_reg, ready_reg;
      logic             main_valid_next, skid_valid_next;
      logic             load, load_main, load_skid, skid_to_main;
      logic [WIDTH-1:0] main_reg, skid_reg;

      assign load = in_valid & ready_reg;

      always_comb begin
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        load_main       = 1'b0;
        load_skid       = 1'b0;
        skid_to_main    = 1'b0;
        if (!main_valid_reg || out_ready) begin
          // main is free this edge: refill from skid first, else from input
          if (skid_valid_reg) begin
            skid_to_main    = 1'b1;
            main_valid_next = 1'b1;
            skid_valid_next = 1'b0;
          end else begin
            load_main       = load;
            main_valid_next = load;
          end
        end else if (load) begin
          load_skid       = 1'b1;
          skid_valid_next = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          main_valid_reg <= 1'b0;
          skid_valid_reg <= 1'b0;
          ready_reg      <= 1'b0;
        end else begin
          main_valid_reg <= main_valid_next;
          skid_valid_reg <= skid_valid_next;
          ready_reg      <= ~skid_valid_next;
        end
      end

      always_ff @(posedge clk) begin
        if (skid_to_main)   main_reg <= skid_reg;
        else if (load_main) main_reg <= in_data;
        if (load_skid)      skid_reg <= in_data;
      end

      assign in_ready  = ready_reg;
      assign out_valid = main_valid_reg;
      assign out_data  = main_reg;
    end
  endgenerate
endmodule

module axi4_reg_slice #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int AW_MODE         = 2,
  parameter int W_MODE          = 2,
  parameter int B_MODE          = 2,
  parameter int AR_MODE         = 2,
  parameter int R_MODE          = 2,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // upstream
  input  logic [ID_WIDTH-1:0]     S_AWID,
  input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
  input  logic [7:0]              S_AWLEN,
  input  logic [2:0]              S_AWSIZE,
  input  logic [1:0]              S_AWBURST,
  input  logic                    S_AWLOCK,
  input  logic [3:0]              S_AWCACHE,
  input  logic [2:0]              S_AWPROT,
  input  logic [3:0]              S_AWQOS,
  input  logic [3:0]              S_AWREGION,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WLAST,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [ID_WIDTH-1:0]     S_BID,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ID_WIDTH-1:0]     S_ARID,
  input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
  input  logic [7:0]              S_ARLEN,
  input  logic [2:0]              S_ARSIZE,
  input  logic [1:0]              S_ARBURST,
  input  logic                    S_ARLOCK,
  input  logic [3:0]              S_ARCACHE,
  input  logic [2:0]              S_ARPROT,
  input  logic [3:0]              S_ARQOS,
  input  logic [3:0]              S_ARREGION,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [ID_WIDTH-1:0]     S_RID,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RLAST,
  output logic                    S_RVALID,
  input  logic                    S_RREADY,
  // downstream
  output logic [ID_WIDTH-1:0]     M_AWID,
  output logic [ADDR_WIDTH-1:0]   M_AWADDR,
  output logic [7:0]              M_AWLEN,
  output logic [2:0]              M_AWSIZE,
  output logic [1:0]              M_AWBURST,
  output logic                    M_AWLOCK,
  output logic [3:0]              M_AWCACHE,
  output logic [2:0]              M_AWPROT,
  output logic [3:0]              M_AWQOS,
  output logic [3:0]              M_AWREGION,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WLAST,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [ID_WIDTH-1:0]     M_BID,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ID_WIDTH-1:0]     M_ARID,
  output logic [ADDR_WIDTH-1:0]   M_ARADDR,
  output logic [7:0]              M_ARLEN,
  output logic [2:0]              M_ARSIZE,
  output logic [1:0]              M_ARBURST,
  output logic                    M_ARLOCK,
  output logic [3:0]              M_ARCACHE,
  output logic [2:0]              M_ARPROT,
  output logic [3:0]              M_ARQOS,
  output logic [3:0]              M_ARREGION,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [ID_WIDTH-1:0]     M_RID,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RLAST,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
);
  localparam int AX_W = ID_WIDTH + ADDR_WIDTH + 29;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH/8 + 1;
  localparam int B_W  = ID_WIDTH + 2;
  localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3;

  logic aw_ready, aw_block, ar_ready, ar_block;

  `ifdef AXI4_SLICE_OUTSTANDING_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic aw_fire, b_fire, ar_fire, r_fire;

  assign aw_fire  = S_AWVALID & S_AWREADY;
  assign b_fire   = S_BVALID & S_BREADY;
  assign ar_fire  = S_ARVALID & S_ARREADY;
  assign r_fire   = S_RVALID & S_RREADY & S_RLAST;
  assign aw_block = (wr_cnt == CNT_W'(MAX_OUTSTANDING));
  assign ar_block = (rd_cnt == CNT_W'(MAX_OUTSTANDING));

  // Saturating at both ends; simultaneous inc/dec leaves the count alone
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (aw_fire && !b_fire && !aw_block)       wr_cnt <= wr_cnt + 1'b1;
      else if (b_fire && !aw_fire && wr_cnt != '0) wr_cnt <= wr_cnt - 1'b1;
      if (ar_fire && !r_fire && !ar_block)       rd_cnt <= rd_cnt + 1'b1;
      else if (r_fire && !ar_fire && rd_cnt != '0) rd_cnt <= rd_cnt - 1'b1;
    end
  end

  `ifndef SYNTHESIS
  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      assert (!(b_fire && !aw_fire && wr_cnt == '0)) else $error("wr_cnt decrement at zero");
      assert (!(r_fire && !ar_fire && rd_cnt == '0)) else $error("rd_cnt decrement at zero");
    end
  end
  `endif
  `else
  assign aw_block = 1'b0;
  assign ar_block = 1'b0;
  `endif

  assign S_AWREADY = aw_ready & ~aw_block;
  assign S_ARREADY = ar_ready & ~ar_block;

  axi4_reg_slice_stage #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
    .clk(ACLK), .rst(ARESET),
    .in_valid(S_AWVALID & ~aw_block), .in_ready(aw_ready),
    .in_data({S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWLOCK,
              S_AWCACHE, S_AWPROT, S_AWQOS, S_AWREGION}),
    .out_valid(M_AWVALID), .out_ready(M_AWREADY),
    .out_data({M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWLOCK,
               M_AWCACHE, M_AWPROT, M_AWQOS, M_AWREGION})
  );

  axi4_reg_slice_stage #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
    .clk(ACLK), .rst(ARESET),
    .in_valid(S_WVALID), .in_ready(S_WREADY),
    .in_data({S_WDATA, S_WSTRB, S_WLAST}),
    .out_valid(M_WVALID), .out_ready(M_WREADY),
    .out_data({M_WDATA, M_WSTRB, M_WLAST})
  );

  axi4_reg_slice_stage #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
    .clk(ACLK), .rst(ARESET),
    .in_valid(M_BVALID), .in_ready(M_BREADY),
    .in_data({M_BID, M_BRESP}),
    .out_valid(S_BVALID), .out_ready(S_BREADY),
    .out_data({S_BID, S_BRESP})
  );

  axi4_reg_slice_stage #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
    .clk(ACLK), .rst(ARESET),
    .in_valid(S_ARVALID & ~ar_block), .in_ready(ar_ready),
    .in_data({S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARLOCK,
              S_ARCACHE, S_ARPROT, S_ARQOS, S_ARREGION}),
    .out_valid(M_ARVALID), .out_ready(M_ARREADY),
    .out_data({M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARLOCK,
               M_ARCACHE, M_ARPROT, M_ARQOS, M_ARREGION})
  );

  axi4_reg_slice_stage #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
    .clk(ACLK), .rst(ARESET),
    .in_valid(M_RVALID), .in_ready(M_RREADY),
    .in_data({M_RID, M_RDATA, M_RRESP, M_RLAST}),
    .out_valid(S_RVALID), .out_ready(S_RREADY),
    .out_data({S_RID, S_RDATA, S_RRESP, S_RLAST})
  );
endmodule

// File: doc/axi4_reg_slice.md
# axi4_reg_slice

Parametrised AXI4 register slice that retimes all five AXI4 channels (AW, W, B, AR, R) between an upstream master and a downstream slave. Each channel has its own compile-time mode: bypass, light (single register) or full (two-entry skid buffer). The block is inserted on long or congested AXI4 paths between the interconnect and the shell's memory-mapped endpoints. It also provides an optional limit on outstanding read and write transactions.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; WSTRB is DATA_WIDTH/8
- ID_WIDTH, 4, ID width
- AW_MODE, W_MODE, B_MODE, AR_MODE, R_MODE, 2, per-channel mode: 0 = bypass, 1 = light, 2 = full
- MAX_OUTSTANDING, 16, outstanding-transaction limit per direction, 1..255; used only with AXI4_SLICE_OUTSTANDING_LIMIT_EN
- ACLK  in  1  clock for all channels
- ARESET  in  1  asynchronous, active-high reset
- S_AW{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS,REGION,VALID}  in  AXI4 widths  upstream write-address channel; S_AWREADY out
- S_W{DATA,STRB,LAST,VALID}  in  AXI4 widths  upstream write-data channel; S_WREADY out
- S_B{ID,RESP,VALID}  out  AXI4 widths  upstream write-response channel; S_BREADY in
- S_AR{…same fields as AW…,VALID}  in  AXI4 widths  upstream read-address channel; S_ARREADY out
- S_R{ID,DATA,RESP,LAST,VALID}  out  AXI4 widths  upstream read-data channel; S_RREADY in
- M_*  mirror of S_*  same widths  downstream side, with directions inverted

## Operation
- Each channel is an independent VALID/READY pipe carrying a packed payload (all fields except VALID/READY). No reordering or modification of fields.
- **Mode 0, bypass:** combinational wires. Zero latency, no state.
- **Mode 1, light:** one payload register plus a valid flag.
  - Input READY = !valid_q.
  - Load on input handshake; clear on output handshake.
  - Throughput: one beat per 2 cycles. Both READY paths are registered.
- **Mode 2, full:** main register plus skid register.
  - Input READY = !skid_valid_q, registered.
  - Output VALID = main_valid_q.
  - Input beat while main is empty, or while main drains in the same cycle: goes to main.
  - Input beat while main is held (output not ready): goes to skid, and READY drops next cycle.
  - On output handshake with skid full: skid moves to main, and READY rises next cycle.
  - Sustains one beat per cycle. Never drops or duplicates a beat.
- **VALID stability:** once output VALID is asserted, payload and VALID stay stable until READY.

## Timing
- **Reset (ARESET high), all modes 1/2:**
  - Every output VALID = 0 and every input READY = 0.
  - Payload registers are don't-care, not reset.
  - Bypass channels follow their inputs, gated: READY and VALID forced to 0 while ARESET = 1.
- **After reset:** READY rises on the first ACLK edge after ARESET deasserts.
- **Latency:** mode 1 and mode 2 add exactly 1 cycle from input handshake to output VALID.
- **Reset mid-burst:** all buffered beats are discarded. The outstanding counters return to 0.
- **Simultaneous load and unload in mode 2:** with main full and skid empty, main is replaced in the same edge and READY stays 1.

## Configuration
- **AXI4_SLICE_OUTSTANDING_LIMIT_EN defined:** adds write and read counters, each $clog2(MAX_OUTSTANDING+1) bits wide, reset to 0.
  - wr_cnt increments on the S_AW handshake and decrements on the S_B handshake.
  - rd_cnt increments on the S_AR handshake and decrements on an S_R handshake with RLAST = 1.
  - Increment and decrement in the same cycle leave the count unchanged.
  - When a count equals MAX_OUTSTANDING, S_AWREADY (respectively S_ARREADY) is forced to 0, and the AW/AR stage accepts nothing until a completion.
  - The counters never wrap. Decrement at 0 is illegal: it asserts in simulation and holds at 0.
- **Macro undefined:** no counters; address channels are gated only by buffer state.

## Test plan
- **Reset release:** all modes = 2; hold ARESET 5 cycles, then release.
  - Expected: all READY = 0 and all VALID = 0 during reset; S_AWREADY = 1 exactly one edge after release.
- **Full throughput:** W_MODE = 2; 256 back-to-back W beats with DATA = index and M_WREADY = 1.
  - Expected: M side sees 256 beats on consecutive cycles, 1-cycle latency, data in order, WLAST on beat 255.
- **Skid backpressure:** W_MODE = 2; drop M_WREADY for 3 cycles mid-stream.
  - Expected: exactly 2 beats are held (main + skid); S_WREADY = 0 from the second held cycle; no loss or duplication after resume.
- **Light mode:** R_MODE = 1; S_RREADY = 1 with continuous M_RVALID.
  - Expected: S_RVALID is asserted on alternate cycles; 10 beats take 20 cycles.
- **Outstanding limit:** macro defined, MAX_OUTSTANDING = 4; issue 6 AR with no R returned.
  - Expected: 4 accepted, then S_ARREADY = 0.
  - Return one R with RLAST = 1: the 5th AR is accepted the following cycle.
- **Reset mid-operation:** assert ARESET with 2 beats buffered and wr_cnt = 3.
  - Expected: M_WVALID = 0 immediately (asynchronous); wr_cnt = 0 after release.
